// File: rtl/unshift_seq_pkg.sv
// Shared shifter package: forward-op codes and the unshift sequencer state encoding.
package unshift_seq_pkg;

  // Forward operation that the sequencer undoes. The value is also the
  // select index of the step mux in unshift_seq.
  localparam logic [1:0] OP_ROL = 2'b00;  // undone by rotate right
  localparam logic [1:0] OP_SLL = 2'b01;  // undone by logical right, MSB fill 0
  localparam logic [1:0] OP_ROR = 2'b10;  // undone by rotate left
  localparam logic [1:0] OP_SRL = 2'b11;  // undone by logical left, LSB fill 0

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/mux_4by16.sv
// Four-input word multiplexer used to pick the one-bit step result.
module mux_4by16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  input  logic [1:0]       i_sel,
  output logic [WIDTH-1:0] o_y
);

  // Select one of the four words; all select values are covered.
  always_comb begin
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/unshift_seq.sv
// Unshift sequencer: undoes a rotate/shift by applying the inverse
// one-bit step once per clock, cnt times, then pulses done for one cycle.
module unshift_seq
  import unshift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_data,  w_data_nxt;
  logic [1:0]       r_op,    w_op_nxt;

  logic [WIDTH-1:0] w_step_ror;
  logic [WIDTH-1:0] w_step_srl;
  logic [WIDTH-1:0] w_step_rol;
  logic [WIDTH-1:0] w_step_sll;
  logic [WIDTH-1:0] w_step;
  logic             w_accept;

  // Inverse single-bit steps, ordered by the forward op code they undo.
  assign w_step_ror = {r_data[0], r_data[WIDTH-1:1]};   // undoes OP_ROL
  assign w_step_srl = {1'b0, r_data[WIDTH-1:1]};        // undoes OP_SLL
  assign w_step_rol = {r_data[WIDTH-2:0], r_data[WIDTH-1]}; // undoes OP_ROR
  assign w_step_sll = {r_data[WIDTH-2:0], 1'b0};        // undoes OP_SRL

  mux_4by16 #(.WIDTH(WIDTH)) u_step_mux (
    .i_d0  (w_step_ror),
    .i_d1  (w_step_srl),
    .i_d2  (w_step_rol),
    .i_d3  (w_step_sll),
    .i_sel (r_op),
    .o_y   (w_step)
  );

  // A start is only taken when no operation is in flight; while rst is high
  // the registers are held in reset, so a start there has no effect.
  assign w_accept = start && (r_state != SHIFT);

  // Next-state, count, data and op selection.
  always_comb begin
    // NOTE: every output gets a hold value first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_data_nxt  = r_data;
    w_op_nxt    = r_op;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_data_nxt  = in;
          w_count_nxt = cnt;
          w_op_nxt    = op;
          w_state_nxt = (cnt == '0) ? DONE : SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        w_data_nxt  = w_step;
        w_count_nxt = r_count - CNT_W'(1);
        if (r_count == CNT_W'(1)) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, count, data and op registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_data  <= '0;
      r_op    <= OP_ROL;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_data  <= w_data_nxt;
      r_op    <= w_op_nxt;
    end
  end

  assign out  = r_data;
  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_unshift_seq.sv
// Scoreboard bench for unshift_seq: the driver pushes the expected result and
// done cycle per accepted start; a monitor pops and compares on every done.
module tb_unshift_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in;
  logic [3:0]  cnt;
  logic [1:0]  op;
  logic [15:0] out;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] data;
    int          cyc;
    int          nbusy;
  } exp_t;

  exp_t sb[$];
  int   cyc       = 0;
  int   busy_run  = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  unshift_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in),
    .cnt   (cnt),
    .op    (op),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the oldest pending expectation.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done got done=1 out=%0h exp no pending result (cycle %0d)", out, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out", out, e.data);
          check("done_cycle", cyc, e.cyc);
          check("busy_cycles", busy_run, e.nbusy);
        end
        busy_run = 0;
      end
    end
  end

  // Drive one start (called at a negedge); returns at the negedge after the edge.
  task automatic issue(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o,
                       input logic [15:0] exp_data, input bit push);
    exp_t e;
    start = 1'b1;
    in    = d;
    cnt   = c;
    op    = o;
    if (push) begin
      e.data  = exp_data;
      e.cyc   = cyc + int'(c) + 1;
      e.nbusy = int'(c);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    in    = 16'hxxxx;
    cnt   = 4'hx;
    op    = 2'bxx;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout got done=0 exp done=1 within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic run_op(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o,
                        input logic [15:0] exp_data);
    issue(d, c, o, exp_data, 1'b1);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no end exp end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    in    = '0;
    cnt   = '0;
    op    = '0;
    repeat (2) @(negedge clk);
    // A start while in reset must be ignored.
    start = 1'b1;
    in    = 16'h5555;
    cnt   = 4'd0;
    @(negedge clk);
    check("rst_out", out, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);

    // Basic undo operations.
    run_op(16'h2001, 4'd1,  2'b00, 16'h9000);
    run_op(16'h00F0, 4'd4,  2'b11, 16'h0F00);
    run_op(16'h8001, 4'd15, 2'b10, 16'hC000);
    run_op(16'hFFFF, 4'd8,  2'b01, 16'h00FF);
    run_op(16'hA5A5, 4'd0,  2'b01, 16'hA5A5);
    run_op(16'hA5A5, 4'd0,  2'b10, 16'hA5A5);

    // Start pulsed mid-SHIFT is ignored.
    issue(16'h00F0, 4'd4, 2'b11, 16'h0F00, 1'b1);
    @(negedge clk);
    issue(16'hFFFF, 4'd1, 2'b00, 16'h0000, 1'b0);
    wait_done();
    @(negedge clk);

    // Start in the DONE cycle: back-to-back reload.
    issue(16'h0003, 4'd2, 2'b00, 16'hC000, 1'b1);
    wait_done();
    issue(16'h0F00, 4'd3, 2'b01, 16'h01E0, 1'b1);
    wait_done();
    @(negedge clk);

    // Reset during SHIFT aborts without a done pulse.
    issue(16'hBEEF, 4'd10, 2'b00, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out", out, 16'h0000);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    run_op(16'h1234, 4'd3, 2'b11, 16'h91A0);

    repeat (3) @(negedge clk);
    check("pending_results", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unshift_seq.md
UNSHIFT_SEQ -- requirements
Module: unshift_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits.
REQ-002 SHALL have parameter CNT_W, default 4, count width in bits (log2 WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port in  input  WIDTH  operand, sampled when a start is accepted.
REQ-007 SHALL have port cnt  input  CNT_W  shift amount, sampled when a start is accepted.
REQ-008 SHALL have port op  input  2  forward-op code to undo: 00 rotate-left, 01 shift-left-logical, 10 rotate-right, 11 shift-right-logical.
REQ-009 SHALL have port out  output  WIDTH  result register.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when out holds a new result.

Function
REQ-012 SHALL, per accepted op, apply the inverse one-bit step cnt times: 00 -> rotate right; 01 -> logical right, MSB fill 0; 10 -> rotate left; 11 -> logical left, LSB fill 0.
REQ-013 SHALL implement states IDLE, SHIFT, DONE; all three are registered.
REQ-014 SHALL accept start only in IDLE or DONE: load data reg <= in, count reg <= cnt, op reg <= op.
REQ-015 SHALL go IDLE/DONE -> SHIFT on an accepted start with cnt != 0, and IDLE/DONE -> DONE on an accepted start with cnt == 0.
REQ-016 SHALL, in SHIFT, perform exactly one step per cycle and decrement the count; the step that takes the count to 0 moves the state to DONE.
REQ-017 SHALL make DONE last one cycle, then move to IDLE unless a new start is accepted in that cycle.
REQ-018 SHALL assert done only in DONE, for exactly one cycle per accepted start.
REQ-019 SHALL have latency: done is high in the cycle cnt+1 clocks after the accepting edge (cnt=0 -> 1 cycle; cnt=15 -> 16 cycles).
REQ-020 SHALL drive busy high in SHIFT only; busy is low in IDLE and in DONE.
REQ-021 SHALL ignore start while busy; in, cnt and op are don't-care outside an accepting cycle.
REQ-022 SHALL drive out from the data register; out is valid in DONE and holds until the next accepted start reloads it.
REQ-023 SHALL mask the step count to CNT_W bits (no wrap beyond WIDTH-1 steps).
REQ-024 SHALL behave as a plain reload on a start in the DONE cycle; the done pulse for the prior result is still emitted.

Reset
REQ-025 SHALL, on rst asserted asynchronously: state=IDLE, out=0, count=0, op reg=00, busy=0, done=0.
REQ-026 SHALL abort any operation on rst mid-SHIFT, with no done pulse for that operation.
REQ-027 SHALL ignore start in any cycle where rst is high.

Structure
REQ-028 SHALL place op-code constants (OP_ROL, OP_SLL, OP_ROR, OP_SRL) and the state encoding (IDLE, SHIFT, DONE) in the shared shifter package.
REQ-029 SHALL select the one-bit step result with the existing mux_4by16, driven by the op register; the four single-bit step nets are built locally.
REQ-030 SHALL use a single always block for state/count/data registers; next-state logic is combinational.

Verification
REQ-031 SHALL be tested with op=00, in=16'h2001, cnt=1 -> out=16'h9000, done 2 cycles after start.
REQ-032 SHALL be tested with op=11, in=16'h00F0, cnt=4 -> out=16'h0F00, busy high 4 cycles, done 5 cycles after start.
REQ-033 SHALL be tested with op=10, in=16'h8001, cnt=15 -> out=16'hC000, done 16 cycles after start; op=01, in=16'hFFFF, cnt=8 -> out=16'h00FF.
REQ-034 SHALL be tested with cnt=0, in=16'hA5A5, any op -> out=16'hA5A5, busy never high, done 1 cycle after start.
REQ-035 SHALL be tested with start pulsed again mid-SHIFT -> ignored, original result and latency unchanged; start in the DONE cycle -> back-to-back operation accepted.
REQ-036 SHALL be tested with rst asserted during SHIFT of cnt=10 -> out=0, busy=0, done never pulses for that operation; next start completes normally.
